// File: rtl/keypad_entry_buffer_pkg.sv
// Shared types and constants for the keypad entry buffer: filter state
// encoding, digit-class decode and default command-key codes.
package keypad_entry_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_HELD    = 2'd2,
    S_RELEASE = 2'd3
  } kp_state_e;

  localparam logic [3:0] MAX_DIGIT_KEY = 4'd9;

  localparam logic [3:0] DEF_ENTER_KEY = 4'hA;
  localparam logic [3:0] DEF_BACK_KEY  = 4'hB;
  localparam logic [3:0] DEF_CLEAR_KEY = 4'hC;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= MAX_DIGIT_KEY;
  endfunction

endpackage

// File: rtl/keypad_entry_buffer_if.sv
// Scanner-side inputs and display-side outputs of the keypad entry buffer,
// plus the filter state for observation.
interface keypad_entry_buffer_if #(
  parameter int N_DIGITS = 4
) ();
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int VW = 4 * N_DIGITS;

  // KEY_VAL is meaningful only while KEY_PRESSED is high; there is no ready.
  // LOAD, COMMIT and REJECT are single-cycle strobes with no backpressure:
  // the consumer must sample them on the cycle they are high.
  logic                         KEY_PRESSED;
  logic [3:0]                   KEY_VAL;
  logic [VW-1:0]                VALUE;
  logic [CW-1:0]                DIGIT_COUNT;
  logic                         LOAD;
  logic                         COMMIT;
  logic [VW-1:0]                COMMIT_VALUE;
  logic                         REJECT;
  keypad_entry_pkg::kp_state_e  DBG_STATE;

  modport master (
    output KEY_PRESSED, KEY_VAL,
    input  VALUE, DIGIT_COUNT, LOAD, COMMIT, COMMIT_VALUE, REJECT, DBG_STATE
  );

  modport slave (
    input  KEY_PRESSED, KEY_VAL,
    output VALUE, DIGIT_COUNT, LOAD, COMMIT, COMMIT_VALUE, REJECT, DBG_STATE
  );

endinterface

// File: rtl/keypad_entry_buffer_key_press_filter.sv
// Synchronises the raw scanner level/code and qualifies each press with a
// stable-hold filter; emits a one-cycle accept together with the held code.
module key_press_filter
  import keypad_entry_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pressed,
  input  logic [3:0] i_key,
  output logic       o_accept,
  output logic [3:0] o_key,
  output kp_state_e  o_state
);

  localparam int                CNT_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic             r_p_meta;
  logic             r_p_s;
  logic [3:0]       r_v_meta;
  logic [3:0]       r_v_s;

  kp_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_key_q;
  logic             r_accept;

  kp_state_e        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_key_nxt;
  logic             w_accept_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_p_meta <= 1'b0;
      r_p_s    <= 1'b0;
      r_v_meta <= 4'h0;
      r_v_s    <= 4'h0;
    end else begin
      r_p_meta <= i_pressed;
      r_p_s    <= r_p_meta;
      r_v_meta <= i_key;
      r_v_s    <= r_v_meta;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_key_q  <= 4'h0;
      r_accept <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_key_q  <= w_key_nxt;
      r_accept <= w_accept_nxt;
    end
  end

  // Accept is registered so the entry datapath acts one edge after HELD.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_key_nxt    = r_key_q;
    w_accept_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_p_s) begin
          w_key_nxt   = r_v_s;
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = S_PRESS;
        end
      end
      S_PRESS: begin
        if (!r_p_s || (r_v_s != r_key_q)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_nxt    = '0;
          w_state_nxt  = S_HELD;
          w_accept_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_HELD: begin
        if (!r_p_s) begin
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (r_p_s) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_accept = r_accept;
    o_key    = r_key_q;
    o_state  = r_state;
  end

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: filtered key presses build a right-shifting decimal
// entry with enter/backspace/clear, and drive the display via a LOAD strobe.
module keypad_entry_buffer
  import keypad_entry_pkg::*;
#(
  parameter int         N_DIGITS      = 4,
  parameter int         STABLE_CYCLES = 16,
  parameter logic [3:0] ENTER_KEY     = DEF_ENTER_KEY,
  parameter logic [3:0] BACK_KEY      = DEF_BACK_KEY,
  parameter logic [3:0] CLEAR_KEY     = DEF_CLEAR_KEY
) (
  input  logic                 CLK,
  input  logic                 RESET,
  keypad_entry_buffer_if.slave bus
);

  localparam int             CW     = $clog2(N_DIGITS + 1);
  localparam int             VW     = 4 * N_DIGITS;
  localparam logic [CW-1:0]  CNT_MAX = CW'(N_DIGITS);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic            w_accept;
  logic [3:0]      w_key;
  kp_state_e       w_state;

  logic [VW-1:0]   r_value;
  logic [CW-1:0]   r_count;
  logic [VW-1:0]   r_commit_value;
  logic            r_upd;
  logic            r_load;
  logic            r_commit;
  logic            r_reject;

  key_press_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_pressed (bus.KEY_PRESSED),
    .i_key     (bus.KEY_VAL),
    .o_accept  (w_accept),
    .o_key     (w_key),
    .o_state   (w_state)
  );

  // r_upd marks an edit of the entry; LOAD trails it by one cycle so the
  // display samples the already-updated VALUE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_value        <= '0;
      r_count        <= '0;
      r_commit_value <= '0;
      r_upd          <= 1'b0;
      r_load         <= 1'b0;
      r_commit       <= 1'b0;
      r_reject       <= 1'b0;
    end else begin
      r_upd    <= 1'b0;
      r_commit <= 1'b0;
      r_reject <= 1'b0;
      r_load   <= r_upd;
      if (w_accept) begin
        if (w_key == ENTER_KEY) begin
          if (r_count != '0) begin
            r_commit_value <= r_value;
            r_commit       <= 1'b1;
            r_value        <= '0;
            r_count        <= '0;
            r_upd          <= 1'b1;
          end
        end else if (w_key == BACK_KEY) begin
          if (r_count != '0) begin
            r_value <= r_value >> 4;
            r_count <= r_count - CNT_ONE;
            r_upd   <= 1'b1;
          end
        end else if (w_key == CLEAR_KEY) begin
          r_value <= '0;
          r_count <= '0;
          r_upd   <= (r_value != '0) || (r_count != '0);
        end else if (is_digit(w_key)) begin
          if (r_count < CNT_MAX) begin
            r_value <= (r_value << 4) | VW'(w_key);
            r_count <= r_count + CNT_ONE;
            r_upd   <= 1'b1;
          end else begin
            r_reject <= 1'b1;
          end
        end else begin
          r_reject <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.VALUE        = r_value;
    bus.DIGIT_COUNT  = r_count;
    bus.LOAD         = r_load;
    bus.COMMIT       = r_commit;
    bus.COMMIT_VALUE = r_commit_value;
    bus.REJECT       = r_reject;
    bus.DBG_STATE    = w_state;
  end

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Bench for keypad_entry_buffer (N_DIGITS=4, STABLE_CYCLES=4): scenario tasks
// with inline checks plus a LOAD/COMMIT scoreboard fed by a small entry model.
module tb_keypad_entry_buffer;
  import keypad_entry_pkg::*;

  localparam int N_DIG  = 4;
  localparam int STABLE = 4;
  localparam int VW     = 4 * N_DIG;
  localparam int CW     = $clog2(N_DIG + 1);
  localparam int W      = CW + VW;

  logic CLK;
  logic RESET;

  keypad_entry_buffer_if #(.N_DIGITS(N_DIG)) dut_if ();

  keypad_entry_buffer #(
    .N_DIGITS      (N_DIG),
    .STABLE_CYCLES (STABLE)
  ) u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (dut_if)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks;
  int failures;
  int load_seen;
  int commit_seen;
  int rej_seen;

  // expected {DIGIT_COUNT, VALUE} at each LOAD, and COMMIT_VALUE at each COMMIT
  logic [W-1:0]  exp_q[$];
  logic [VW-1:0] commit_q[$];

  logic [VW-1:0] m_value;
  logic [CW-1:0] m_count;
  int            m_loads;
  int            m_commits;
  int            m_rejects;

  task automatic model_apply(input logic [3:0] k);
    if (k == 4'hA) begin
      if (m_count != 0) begin
        commit_q.push_back(m_value);
        m_commits++;
        m_value = '0;
        m_count = '0;
        exp_q.push_back({m_count, m_value});
        m_loads++;
      end
    end else if (k == 4'hB) begin
      if (m_count != 0) begin
        m_value = m_value >> 4;
        m_count = m_count - 1'b1;
        exp_q.push_back({m_count, m_value});
        m_loads++;
      end
    end else if (k == 4'hC) begin
      if ((m_value != 0) || (m_count != 0)) begin
        m_value = '0;
        m_count = '0;
        exp_q.push_back({m_count, m_value});
        m_loads++;
      end
    end else if (k <= 4'd9) begin
      if (m_count < N_DIG) begin
        m_value = {m_value[VW-5:0], k};
        m_count = m_count + 1'b1;
        exp_q.push_back({m_count, m_value});
        m_loads++;
      end else begin
        m_rejects++;
      end
    end else begin
      m_rejects++;
    end
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    if (!RESET) begin
      if (dut_if.LOAD === 1'b1) begin
        logic [W-1:0] e;
        load_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_load: unexpected LOAD, value=%h count=%0d", dut_if.VALUE, dut_if.DIGIT_COUNT);
        end else begin
          e = exp_q.pop_front();
          if ({dut_if.DIGIT_COUNT, dut_if.VALUE} !== e) begin
            failures++;
            $display("FAIL sb_load: got count=%0d value=%h expected count=%0d value=%h",
                     dut_if.DIGIT_COUNT, dut_if.VALUE, e[W-1:VW], e[VW-1:0]);
          end
        end
      end
      if (dut_if.COMMIT === 1'b1) begin
        logic [VW-1:0] c;
        commit_seen++;
        checks++;
        if (commit_q.size() == 0) begin
          failures++;
          $display("FAIL sb_commit: unexpected COMMIT, commit_value=%h", dut_if.COMMIT_VALUE);
        end else begin
          c = commit_q.pop_front();
          if (dut_if.COMMIT_VALUE !== c) begin
            failures++;
            $display("FAIL sb_commit: got %h expected %h", dut_if.COMMIT_VALUE, c);
          end
        end
      end
      if (dut_if.REJECT === 1'b1) rej_seen++;
    end
  end

  // driver tasks
  task automatic do_reset();
    RESET = 1'b1;
    dut_if.KEY_PRESSED = 1'b0;
    dut_if.KEY_VAL = 4'h0;
    repeat (3) @(negedge CLK);
    exp_q.delete();
    commit_q.delete();
    m_value = '0; m_count = '0;
    m_loads = 0; m_commits = 0; m_rejects = 0;
    load_seen = 0; commit_seen = 0; rej_seen = 0;
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic press_key(input logic [3:0] k);
    @(negedge CLK);
    dut_if.KEY_PRESSED = 1'b1;
    dut_if.KEY_VAL = k;
    model_apply(k);
    repeat (STABLE + 6) @(negedge CLK);
    dut_if.KEY_PRESSED = 1'b0;
    repeat (STABLE + 6) @(negedge CLK);
  endtask

  // scenarios
  task automatic test_reset();
    RESET = 1'b1;
    dut_if.KEY_PRESSED = 1'b0;
    dut_if.KEY_VAL = 4'h0;
    repeat (2) @(negedge CLK);
    checks++;
    if (dut_if.VALUE !== 16'h0 || dut_if.DIGIT_COUNT !== 3'd0 || dut_if.LOAD !== 1'b0 ||
        dut_if.COMMIT !== 1'b0 || dut_if.COMMIT_VALUE !== 16'h0 || dut_if.REJECT !== 1'b0 ||
        dut_if.DBG_STATE !== S_IDLE) begin
      failures++;
      $display("FAIL reset_outputs: value=%h count=%0d load=%b commit=%b cv=%h rej=%b state=%0d expected all zero/S_IDLE",
               dut_if.VALUE, dut_if.DIGIT_COUNT, dut_if.LOAD, dut_if.COMMIT,
               dut_if.COMMIT_VALUE, dut_if.REJECT, dut_if.DBG_STATE);
    end
    do_reset();
  endtask

  task automatic test_single_press();
    do_reset();
    @(negedge CLK);
    dut_if.KEY_PRESSED = 1'b1;
    dut_if.KEY_VAL = 4'd5;
    model_apply(4'd5);
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (c == 6) begin
        checks++;
        if (dut_if.VALUE !== 16'h0) begin
          failures++;
          $display("FAIL press_early: value=%h at cycle 6 expected 0000", dut_if.VALUE);
        end
      end
      if (c == 7) begin
        checks++;
        if (dut_if.VALUE !== 16'h0005 || dut_if.DIGIT_COUNT !== 3'd1 || dut_if.LOAD !== 1'b0) begin
          failures++;
          $display("FAIL press_latency: value=%h count=%0d load=%b at cycle 7 expected 0005/1/0",
                   dut_if.VALUE, dut_if.DIGIT_COUNT, dut_if.LOAD);
        end
      end
      if (c == 8) begin
        checks++;
        if (dut_if.LOAD !== 1'b1) begin
          failures++;
          $display("FAIL press_load: load=%b at cycle 8 expected 1", dut_if.LOAD);
        end
      end
      if (c == 9) begin
        checks++;
        if (dut_if.LOAD !== 1'b0) begin
          failures++;
          $display("FAIL press_load_width: load=%b at cycle 9 expected 0", dut_if.LOAD);
        end
      end
    end
    dut_if.KEY_PRESSED = 1'b0;
    repeat (12) @(negedge CLK);
    checks++;
    if (dut_if.VALUE !== 16'h0005 || dut_if.DIGIT_COUNT !== 3'd1 || load_seen !== 1) begin
      failures++;
      $display("FAIL press_no_repeat: value=%h count=%0d loads=%0d expected 0005/1/1",
               dut_if.VALUE, dut_if.DIGIT_COUNT, load_seen);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    @(negedge CLK);
    dut_if.KEY_VAL = 4'd3;
    dut_if.KEY_PRESSED = 1'b1;
    repeat (2) @(negedge CLK);
    dut_if.KEY_PRESSED = 1'b0;
    repeat (2) @(negedge CLK);
    dut_if.KEY_PRESSED = 1'b1;
    model_apply(4'd3);
    for (int c = 1; c <= 16; c++) begin
      @(negedge CLK);
      if (c == 6) begin
        checks++;
        if (dut_if.VALUE !== 16'h0) begin
          failures++;
          $display("FAIL bounce_early: value=%h at cycle 6 expected 0000", dut_if.VALUE);
        end
      end
      if (c == 7) begin
        checks++;
        if (dut_if.VALUE !== 16'h0003 || dut_if.DIGIT_COUNT !== 3'd1) begin
          failures++;
          $display("FAIL bounce_latency: value=%h count=%0d expected 0003/1", dut_if.VALUE, dut_if.DIGIT_COUNT);
        end
      end
    end
    dut_if.KEY_PRESSED = 1'b0;
    repeat (12) @(negedge CLK);
    checks++;
    if (dut_if.DIGIT_COUNT !== 3'd1 || load_seen !== 1) begin
      failures++;
      $display("FAIL bounce_single: count=%0d loads=%0d expected 1/1", dut_if.DIGIT_COUNT, load_seen);
    end
  endtask

  task automatic test_fill_and_back();
    do_reset();
    for (int i = 1; i <= 4; i++) press_key(4'(i));
    checks++;
    if (dut_if.VALUE !== 16'h1234 || dut_if.DIGIT_COUNT !== 3'd4) begin
      failures++;
      $display("FAIL fill: value=%h count=%0d expected 1234/4", dut_if.VALUE, dut_if.DIGIT_COUNT);
    end
    press_key(4'd5);
    checks++;
    if (dut_if.VALUE !== 16'h1234 || rej_seen !== 1 || load_seen !== 4) begin
      failures++;
      $display("FAIL full_reject: value=%h rejects=%0d loads=%0d expected 1234/1/4",
               dut_if.VALUE, rej_seen, load_seen);
    end
    press_key(4'hB);
    checks++;
    if (dut_if.VALUE !== 16'h0123 || dut_if.DIGIT_COUNT !== 3'd3) begin
      failures++;
      $display("FAIL backspace: value=%h count=%0d expected 0123/3", dut_if.VALUE, dut_if.DIGIT_COUNT);
    end
  endtask

  task automatic test_commit();
    do_reset();
    press_key(4'd7);
    press_key(4'd8);
    press_key(4'hA);
    checks++;
    if (dut_if.COMMIT_VALUE !== 16'h0078 || dut_if.VALUE !== 16'h0 ||
        dut_if.DIGIT_COUNT !== 3'd0 || commit_seen !== 1) begin
      failures++;
      $display("FAIL commit: cv=%h value=%h count=%0d commits=%0d expected 0078/0000/0/1",
               dut_if.COMMIT_VALUE, dut_if.VALUE, dut_if.DIGIT_COUNT, commit_seen);
    end
    press_key(4'hA);
    checks++;
    if (commit_seen !== 1 || load_seen !== 3 || dut_if.COMMIT_VALUE !== 16'h0078) begin
      failures++;
      $display("FAIL empty_enter: commits=%0d loads=%0d cv=%h expected 1/3/0078",
               commit_seen, load_seen, dut_if.COMMIT_VALUE);
    end
  endtask

  task automatic test_noops();
    do_reset();
    press_key(4'hB);
    press_key(4'hC);
    checks++;
    if (load_seen !== 0 || dut_if.VALUE !== 16'h0) begin
      failures++;
      $display("FAIL empty_back_clear: loads=%0d value=%h expected 0/0000", load_seen, dut_if.VALUE);
    end
    press_key(4'hE);
    checks++;
    if (rej_seen !== 1 || load_seen !== 0) begin
      failures++;
      $display("FAIL key_e: rejects=%0d loads=%0d expected 1/0", rej_seen, load_seen);
    end
    press_key(4'd6);
    press_key(4'hF);
    press_key(4'hC);
    checks++;
    if (dut_if.VALUE !== 16'h0 || load_seen !== 2 || rej_seen !== 2 || rej_seen !== m_rejects) begin
      failures++;
      $display("FAIL clear_nonempty: value=%h loads=%0d rejects=%0d expected 0000/2/2",
               dut_if.VALUE, load_seen, rej_seen);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_key(4'd4);
    press_key(4'd2);
    checks++;
    if (dut_if.VALUE !== 16'h0042) begin
      failures++;
      $display("FAIL pre_reset_entry: value=%h expected 0042", dut_if.VALUE);
    end
    @(negedge CLK);
    dut_if.KEY_PRESSED = 1'b1;
    dut_if.KEY_VAL = 4'd7;
    repeat (4) @(negedge CLK);
    checks++;
    if (dut_if.DBG_STATE !== S_PRESS) begin
      failures++;
      $display("FAIL mid_press_state: state=%0d expected %0d", dut_if.DBG_STATE, S_PRESS);
    end
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if (dut_if.VALUE !== 16'h0 || dut_if.DIGIT_COUNT !== 3'd0 || dut_if.LOAD !== 1'b0 ||
        dut_if.COMMIT_VALUE !== 16'h0 || dut_if.DBG_STATE !== S_IDLE) begin
      failures++;
      $display("FAIL async_reset: value=%h count=%0d load=%b cv=%h state=%0d expected all zero/S_IDLE",
               dut_if.VALUE, dut_if.DIGIT_COUNT, dut_if.LOAD, dut_if.COMMIT_VALUE, dut_if.DBG_STATE);
    end
    do_reset();
    press_key(4'd9);
    checks++;
    if (dut_if.VALUE !== 16'h0009 || dut_if.DIGIT_COUNT !== 3'd1) begin
      failures++;
      $display("FAIL post_reset_press: value=%h count=%0d expected 0009/1", dut_if.VALUE, dut_if.DIGIT_COUNT);
    end
  endtask

  task automatic test_random_keys();
    do_reset();
    for (int i = 0; i < 12; i++) press_key(4'($urandom_range(0, 15)));
    checks++;
    if ({dut_if.DIGIT_COUNT, dut_if.VALUE} !== {m_count, m_value} || rej_seen !== m_rejects ||
        load_seen !== m_loads || commit_seen !== m_commits) begin
      failures++;
      $display("FAIL random_keys: count=%0d value=%h rej=%0d loads=%0d commits=%0d expected %0d/%h/%0d/%0d/%0d",
               dut_if.DIGIT_COUNT, dut_if.VALUE, rej_seen, load_seen, commit_seen,
               m_count, m_value, m_rejects, m_loads, m_commits);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RESET = 1'b1;
    dut_if.KEY_PRESSED = 1'b0;
    dut_if.KEY_VAL = 4'h0;
    test_reset();
    test_single_press();
    test_bounce();
    test_fill_and_back();
    test_commit();
    test_noops();
    test_reset_mid();
    test_random_keys();
    repeat (4) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0 || commit_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: pending loads=%0d commits=%0d expected 0/0", exp_q.size(), commit_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_entry_buffer.md
Name: keypad_entry_buffer

Overview:
Sits directly downstream of the keypad scanner and upstream of the multiplexed seven-segment display controller. Takes the scanner's raw pressed level and 4-bit key code, and qualifies each press with a stable-hold filter. Decimal keys build a right-shifting multi-digit entry; command keys perform enter, backspace and clear. Drives the displayed value with a one-cycle LOAD strobe, which removes the display's dependence on clock-ladder timing.

Parameters:
N_DIGITS, 4, digit capacity of the entry register (VALUE width = 4*N_DIGITS)
STABLE_CYCLES, 16, consecutive CLK cycles a press/release must hold before it is accepted (>=2)
ENTER_KEY, 4'hA, key code that commits the entry
BACK_KEY, 4'hB, key code that deletes the last digit
CLEAR_KEY, 4'hC, key code that zeroes the entry

Ports:
CLK  input  1  system clock (single clock domain)
RESET  input  1  asynchronous, active-high reset
KEY_PRESSED  input  1  scanner pressed level, asynchronous to CLK
KEY_VAL  input  4  scanner key code, valid while KEY_PRESSED
VALUE  output  4*N_DIGITS  current entry, newest digit in [3:0]
DIGIT_COUNT  output  $clog2(N_DIGITS+1)  digits currently held
LOAD  output  1  one-cycle pulse, one cycle after any VALUE change
COMMIT  output  1  one-cycle pulse on an accepted ENTER
COMMIT_VALUE  output  4*N_DIGITS  entry captured at last commit, held until the next commit
REJECT  output  1  one-cycle pulse when a digit arrives while full, or on key D/E/F

Behaviour:
- Reset (async, any time, including mid-filter): all outputs are 0, state is S_IDLE, and the counter and synchronisers are 0.
- KEY_PRESSED and KEY_VAL each pass through a 2-flop synchroniser. The synchronised pair is p_s/v_s.
- FSM and counter cnt:
  - S_IDLE: if p_s, latch v_s into key_q, set cnt=1, go to S_PRESS.
  - S_PRESS: if !p_s or v_s!=key_q, go to S_IDLE with cnt=0 (bounce). Otherwise cnt++. When cnt==STABLE_CYCLES-1 on this edge, go to S_HELD and assert the internal accept for exactly one cycle.
  - S_HELD: if !p_s, set cnt=1 and go to S_RELEASE. A held key never repeats.
  - S_RELEASE: if p_s, go to S_HELD (bounce, no new action). Otherwise cnt++. At cnt==STABLE_CYCLES-1, go to S_IDLE.
- Action on accept (registered, takes effect the edge after accept):
  - Key 0-9 with DIGIT_COUNT<N_DIGITS: VALUE <= {VALUE[4*N_DIGITS-5:0], key_q}, and DIGIT_COUNT increments.
  - Key 0-9 when full: VALUE is unchanged and REJECT pulses.
  - BACK_KEY: VALUE <= VALUE>>4 and DIGIT_COUNT decrements. When empty, this is a no-op with no LOAD.
  - CLEAR_KEY: VALUE and DIGIT_COUNT become 0. LOAD pulses only if VALUE or DIGIT_COUNT was nonzero.
  - ENTER_KEY with DIGIT_COUNT>0: COMMIT_VALUE <= VALUE, COMMIT pulses, VALUE and DIGIT_COUNT become 0, and LOAD pulses. When empty, it is ignored entirely.
  - Keys D, E, F: REJECT pulses and nothing else changes.
- LOAD asserts in the cycle after the VALUE register changes, so the display always samples the new value.
- Total latency from a clean KEY_PRESSED edge to VALUE update is 2 + STABLE_CYCLES + 1 cycles. LOAD follows 1 cycle later.
- No multi-key handling is needed: a change in the key code during S_PRESS restarts filtering.

Decomposition:
- Package keypad_entry_pkg holds:
  - the state enum (S_IDLE, S_PRESS, S_HELD, S_RELEASE);
  - localparams for the digit-class decode (key<=9);
  - default command-key codes.
- One natural sub-module, key_press_filter, owns the synchroniser, FSM, counter and key_q. It emits accept and key_q.
- The parent owns the entry datapath and the output strobes.

Test Plan:
- STABLE_CYCLES=4. Clean press of key 5 held for 20 cycles, then released:
  - VALUE=16'h0005 and DIGIT_COUNT=1 exactly 7 cycles after the press.
  - LOAD pulses once at cycle 8.
  - No repeat occurs.
- Bounce: KEY_PRESSED toggles 1,0,1 with 2-cycle pulses, then stays stable. Exactly one digit is accepted, timed from the last rising edge.
- Keys 1,2,3,4,5: VALUE=16'h1234, DIGIT_COUNT=4, and the fifth key produces REJECT=1 with VALUE unchanged. B then gives VALUE=16'h0123 and DIGIT_COUNT=3.
- Entry 7,8 followed by A:
  - COMMIT pulses with COMMIT_VALUE=16'h0078.
  - VALUE=0 and DIGIT_COUNT=0.
  - A second A produces no COMMIT and no LOAD.
- B on an empty entry, and key E: no LOAD. E alone produces REJECT.
- RESET asserted mid-S_PRESS and mid-entry (VALUE=16'h0042): all outputs clear asynchronously. The next clean press of 9 gives VALUE=16'h0009.
